// File: rtl/note_envelope_ctrl.sv
// ---------------------------------------------------------------------------
// note_envelope_ctrl
//   Decay envelope sequencer for one synthesiser voice. Counts sample strobes
//   since note onset and steps a 6-bit decay index into an external gain
//   lookup (8-bit unsigned, 128 = 1.0). The returned gain is applied to the
//   voice sample stream through a two-stage pipeline. On key release the
//   index freezes and the output fades by a growing right shift until the
//   voice falls silent.
//
// Ports
//   clk               system clock
//   rst               asynchronous active-high reset
//   note_start        one-cycle pulse, begin or retrigger a note
//   note_stop         one-cycle pulse, key released
//   sample_in_valid   one-cycle strobe per audio sample
//   sample_in         signed raw voice sample
//   env_index         registered decay index to the gain lookup
//   env_gain          gain for the current env_index (combinational return)
//   sample_out        signed enveloped sample, held between strobes
//   sample_out_valid  sample_in_valid delayed by two cycles
//   active            high in DECAY, SUSTAIN or RELEASE
//   done              one-cycle pulse on RELEASE -> IDLE
//
// Build option
//   ENV_GAIN_ROUND_EN  when defined, stage 2 rounds half up before the shift;
//                      otherwise the shift floors toward minus infinity.
//
// States
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no note; enveloped output forced to 0
//   ST_DECAY   | index advances once every STEP_DIV strobes
//   ST_SUSTAIN | index parked at 63 (table floor)
//   ST_RELEASE | index frozen; fade shift grows once every REL_DIV strobes
// ---------------------------------------------------------------------------
module note_envelope_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int STEP_DIV = 256,
  parameter int REL_DIV  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       note_start,
  input  logic                       note_stop,
  input  logic                       sample_in_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic [5:0]                 env_index,
  input  logic [7:0]                 env_gain,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_out_valid,
  output logic                       active,
  output logic                       done
);

  localparam int PROD_W  = SAMPLE_W + 9;
  localparam int DIV_MAX = (STEP_DIV > REL_DIV) ? STEP_DIV : REL_DIV;
  localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

  // Strobe timer is a down-counter: reload value means "zero strobes
  // elapsed", terminal count 0 marks the strobe that completes a period.
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] REL_LOAD  = CNT_W'(REL_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECAY   = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       shift_q, shift_d;
  logic             done_q, done_d;

  // -------------------------------------------------------------------------
  // Envelope sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= STEP_LOAD;
      shift_q <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;

    if (note_start) begin
      // Start overrides everything, including a simultaneous stop or strobe.
      state_d = ST_DECAY;
      idx_d   = 6'd0;
      cnt_d   = STEP_LOAD;
      shift_d = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_DECAY: begin
          if (note_stop) begin
            state_d = ST_RELEASE;
            cnt_d   = REL_LOAD;
          end else if (sample_in_valid) begin
            if (cnt_q == '0) begin
              cnt_d = STEP_LOAD;
              idx_d = idx_q + 6'd1;
              if (idx_q == 6'd62) begin
                state_d = ST_SUSTAIN;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        ST_SUSTAIN: begin
          if (note_stop) begin
            state_d = ST_RELEASE;
            cnt_d   = REL_LOAD;
          end
        end

        ST_RELEASE: begin
          if (sample_in_valid) begin
            if (cnt_q == '0) begin
              cnt_d = REL_LOAD;
              if (shift_q == 3'd7) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                shift_d = shift_q + 3'd1;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign env_index = idx_q;
  assign active    = (state_q != ST_IDLE);
  assign done      = done_q;

  // -------------------------------------------------------------------------
  // Gain pipeline
  // -------------------------------------------------------------------------
  logic signed [PROD_W-1:0] mult_a;
  logic signed [PROD_W-1:0] mult_b;
  logic signed [PROD_W-1:0] prod;

  // Gain is unsigned; a zero MSB keeps 128 positive in the signed multiply.
  assign mult_a = {{9{sample_in[SAMPLE_W-1]}}, sample_in};
  assign mult_b = {{(PROD_W-8){1'b0}}, env_gain};
  assign prod   = mult_a * mult_b;

  logic                     s1_valid_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic [2:0]               s1_shift_q;
  logic                     s1_live_q;

  // Stage 1 snapshots gain, shift and state as they stood before this
  // strobe's own update, so in-flight samples are unaffected by a retrigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_shift_q <= 3'd0;
      s1_live_q  <= 1'b0;
    end else begin
      s1_valid_q <= sample_in_valid;
      if (sample_in_valid) begin
        s1_prod_q  <= prod;
        s1_shift_q <= shift_q;
        s1_live_q  <= (state_q != ST_IDLE);
      end
    end
  end

  logic [4:0]               shamt;
  logic signed [PROD_W:0]   acc;
  logic signed [SAMPLE_W-1:0] scaled;

  // One guard bit above the product leaves room for the rounding addend.
  always_comb begin
    shamt = 5'd7 + {2'b00, s1_shift_q};
    acc   = {s1_prod_q[PROD_W-1], s1_prod_q};
`ifdef ENV_GAIN_ROUND_EN
    acc   = acc + ((PROD_W+1)'(1) << (shamt - 5'd1));
`endif
    // Gain never exceeds 1.0, so the truncation cannot lose magnitude.
    scaled = SAMPLE_W'(acc >>> shamt);
  end

  logic                       out_valid_q;
  logic signed [SAMPLE_W-1:0] sample_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sample_out_q <= s1_live_q ? scaled : '0;
      end
    end
  end

  assign sample_out       = sample_out_q;
  assign sample_out_valid = out_valid_q;

endmodule
